// File: rtl/extract_slots_if.sv
// Bank read ports and software output stream of extract_slots.
// master = extract_slots side, slave = BRAM banks plus software consumer.
interface extract_slots_if #(
  parameter int LOGN         = 13,
  parameter int OVERALL_BITS = 32
);
  logic [LOGN-2:0]           rd_addr_bank0;
  logic [LOGN-2:0]           rd_addr_bank1;
  logic                      rd_en_bank0;
  logic                      rd_en_bank1;
  logic [2*OVERALL_BITS-1:0] rd_data_bank0;
  logic [2*OVERALL_BITS-1:0] rd_data_bank1;
  logic [2*OVERALL_BITS-1:0] data_to_sw;
  logic                      valid_to_sw;
  logic                      ready_from_sw;

  modport master (
    output rd_addr_bank0, rd_addr_bank1, rd_en_bank0, rd_en_bank1,
    input  rd_data_bank0, rd_data_bank1,
    output data_to_sw, valid_to_sw,
    input  ready_from_sw
  );

  modport slave (
    input  rd_addr_bank0, rd_addr_bank1, rd_en_bank0, rd_en_bank1,
    output rd_data_bank0, rd_data_bank1,
    input  data_to_sw, valid_to_sw,
    output ready_from_sw
  );
endinterface

// File: rtl/extract_slots.sv
// Reads FFT result words out of two BRAM banks, either as N/2 slots in
// rotation (powers-of-3) order or as N raw words, and streams them to software.
module extract_slots #(
  parameter int LOGN         = 13,
  parameter int RD_LAT       = 2,
  parameter int OVERALL_BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            do_extract,
  output logic            busy,
  output logic            done,
  extract_slots_if.master bus
);
  localparam int N     = 1 << LOGN;
  localparam int W     = 2 * OVERALL_BITS;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = 4;
  localparam logic [LOGN-1:0] LAST_RAW = LOGN'(N - 1);
  localparam logic [LOGN-1:0] LAST_EXT = LOGN'(N / 2 - 1);
  localparam logic [LOGN:0]   POS_INIT = (LOGN + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [LOGN:0]   pos_q, pos_d;
  logic [LOGN-1:0] k_q, k_d;
  logic            en0_q, en0_d, en1_q, en1_d;
  logic [LOGN-2:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [RD_LAT-1:0] vld_q, vld_d, bsel_q, bsel_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [LOGN-1:0] slot, slot_rev, idx;
  logic [CW-1:0]   inflight, total;
  logic            pop, push;
  logic [W-1:0]    push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    slot = LOGN'((pos_q - 1'b1) >> 1);
    slot_rev = '0;
    for (int unsigned i = 0; i < LOGN; i++) slot_rev[i] = slot[LOGN-1-i];
    idx = mode_q ? slot_rev : k_q;
  end

  // Credit counts everything already committed to the FIFO (stored, in the
  // BRAM pipe, or issued last cycle) minus the word leaving this cycle.
  always_comb begin
    inflight = CW'(en0_q | en1_q);
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    total = cnt_q + inflight;
    pop   = (cnt_q != '0) && bus.ready_from_sw;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    k_d     = k_q;
    en0_d   = 1'b0;
    en1_d   = 1'b0;
    addr0_d = '0;
    addr1_d = '0;
    done    = 1'b0;
    busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = do_extract;
          pos_d   = POS_INIT;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if ((total - CW'(pop)) < CW'(DEPTH)) begin
          if (idx[0]) begin
            en1_d   = 1'b1;
            addr1_d = idx[LOGN-1:1];
          end else begin
            en0_d   = 1'b1;
            addr0_d = idx[LOGN-1:1];
          end
          k_d   = k_q + 1'b1;
          pos_d = pos_q + {pos_q[LOGN-1:0], 1'b0};
          if (k_q == (mode_q ? LAST_EXT : LAST_RAW)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (total == CW'(pop)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d     = '0;
    bsel_d    = '0;
    vld_d[0]  = en0_q | en1_q;
    bsel_d[0] = en1_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      bsel_d[i] = bsel_q[i-1];
    end
    push      = vld_q[RD_LAT-1];
    push_data = bsel_q[RD_LAT-1] ? bus.rd_data_bank1 : bus.rd_data_bank0;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      pos_q   <= POS_INIT;
      k_q     <= '0;
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      vld_q   <= '0;
      bsel_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      k_q     <= k_d;
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      vld_q   <= vld_d;
      bsel_q  <= bsel_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: the output is gated by the occupancy count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.rd_en_bank0   = en0_q;
  assign bus.rd_en_bank1   = en1_q;
  assign bus.rd_addr_bank0 = addr0_q;
  assign bus.rd_addr_bank1 = addr1_q;
  assign bus.valid_to_sw   = (cnt_q != '0);
  assign bus.data_to_sw    = (cnt_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: tb/tb_extract_slots.sv
// Directed bench for extract_slots at LOGN=3, RD_LAT=2 with a two-bank BRAM model.
module tb_extract_slots;
  localparam int LOGN = 3;
  localparam int RD_LAT = 2;
  localparam int OB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic do_extract = 1'b0;
  logic busy, done;
  int checks = 0;
  int errors = 0;

  extract_slots_if #(.LOGN(LOGN), .OVERALL_BITS(OB)) bus ();

  extract_slots #(.LOGN(LOGN), .RD_LAT(RD_LAT), .OVERALL_BITS(OB)) dut (
    .clk(clk), .rst(rst), .start(start), .do_extract(do_extract),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Two-stage BRAM model: data visible two cycles after the enable cycle.
  logic [15:0] b0 [4];
  logic [15:0] b1 [4];
  logic [15:0] s1_0 = 16'hEEEE, s2_0 = 16'hEEEE, s1_1 = 16'hEEEE, s2_1 = 16'hEEEE;
  always @(posedge clk) begin
    s1_0 <= bus.rd_en_bank0 ? b0[bus.rd_addr_bank0] : 16'hEEEE;
    s1_1 <= bus.rd_en_bank1 ? b1[bus.rd_addr_bank1] : 16'hEEEE;
    s2_0 <= s1_0;
    s2_1 <= s1_1;
  end
  assign bus.rd_data_bank0 = s2_0;
  assign bus.rd_data_bank1 = s2_1;

  logic [15:0] exp_ex_w [4] = '{16'hA0, 16'hA2, 16'hB0, 16'hB2};
  logic [15:0] exp_raw_w [8] = '{16'hA0, 16'hB0, 16'hA1, 16'hB1, 16'hA2, 16'hB2, 16'hA3, 16'hB3};
  logic [2:0]  exp_ex_r [4] = '{3'd0, 3'd2, 3'd4, 3'd6};
  logic [2:0]  exp_raw_r [8] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};

  logic [15:0] words [$];
  logic [2:0]  reads [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_valid"}, 32'(bus.valid_to_sw), 0);
    chk({tag, "_data"}, 32'(bus.data_to_sw), 0);
    chk({tag, "_rden"}, {30'd0, bus.rd_en_bank1, bus.rd_en_bank0}, 0);
    chk({tag, "_addr"}, {28'd0, bus.rd_addr_bank1, bus.rd_addr_bank0}, 0);
  endtask

  task automatic do_run(input string nm, input bit mode, input bit rnd, input bit poke);
    int off, first_off, last_off, done_off, ndone, n, stall_left;
    logic pv, pr;
    logic [15:0] pd, ew, gw;
    logic [2:0] er, gr;
    words.delete();
    reads.delete();
    first_off = -1; last_off = -1; done_off = -1; ndone = 0; stall_left = 0;
    pv = 1'b0; pr = 1'b1; pd = '0;
    n = mode ? 4 : 8;
    @(negedge clk);
    do_extract = mode;
    start = 1'b1;
    off = 0;
    while (off < 200 && !(ndone > 0 && off >= done_off + 4)) begin
      @(negedge clk);
      off++;
      start = (poke && off == 3);
      if (!rnd) bus.ready_from_sw = 1'b1;
      else if (stall_left > 0) begin
        bus.ready_from_sw = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.ready_from_sw = 1'b0;
        stall_left = 2;
      end else bus.ready_from_sw = 1'b1;
      if (pv && !pr) chk({nm, "_hold"}, {15'd0, bus.valid_to_sw, bus.data_to_sw}, {15'd0, 1'b1, pd});
      chk({nm, "_rd_excl"}, {29'd0, bus.rd_en_bank0 && bus.rd_en_bank1,
          !bus.rd_en_bank0 && bus.rd_addr_bank0 != 0,
          !bus.rd_en_bank1 && bus.rd_addr_bank1 != 0}, 0);
      if (bus.rd_en_bank0) reads.push_back({1'b0, bus.rd_addr_bank0});
      if (bus.rd_en_bank1) reads.push_back({1'b1, bus.rd_addr_bank1});
      if (bus.valid_to_sw && bus.ready_from_sw) begin
        words.push_back(bus.data_to_sw);
        if (first_off < 0) first_off = off;
        last_off = off;
      end
      if (done) begin
        ndone++;
        done_off = off;
        if (poke) start = 1'b1;
      end
      pv = bus.valid_to_sw;
      pr = bus.ready_from_sw;
      pd = bus.data_to_sw;
    end
    start = 1'b0;
    chk({nm, "_ndone"}, ndone, 1);
    chk({nm, "_nwords"}, words.size(), n);
    chk({nm, "_nreads"}, reads.size(), n);
    for (int i = 0; i < n; i++) begin
      ew = mode ? exp_ex_w[i] : exp_raw_w[i];
      er = mode ? exp_ex_r[i] : exp_raw_r[i];
      gw = (i < words.size()) ? words[i] : 16'hxxxx;
      gr = (i < reads.size()) ? reads[i] : 3'bxxx;
      chk($sformatf("%s_word%0d", nm, i), 32'(gw), 32'(ew));
      chk($sformatf("%s_read%0d", nm, i), 32'(gr), 32'(er));
    end
    chk({nm, "_done_after_last"}, done_off, last_off + 1);
    chk({nm, "_first_latency"}, 32'(first_off >= 2 + RD_LAT), 1);
    if (!rnd) chk({nm, "_back_to_back"}, last_off - first_off, n - 1);
    chk({nm, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    logic saw;
    for (int a = 0; a < 4; a++) begin
      b0[a] = 16'hA0 + 16'(a);
      b1[a] = 16'hB0 + 16'(a);
    end
    bus.ready_from_sw = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    do_run("ext", 1'b1, 1'b0, 1'b0);
    do_run("raw", 1'b0, 1'b0, 1'b0);
    do_run("ext_stall", 1'b1, 1'b1, 1'b0);
    do_run("ext_poke", 1'b1, 1'b0, 1'b1);

    // Reset with two reads outstanding, then confirm nothing stale escapes.
    @(negedge clk);
    bus.ready_from_sw = 1'b1;
    do_extract = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.valid_to_sw || busy || done) saw = 1'b1;
    end
    chk("no_stale_after_reset", 32'(saw), 0);
    do_run("ext_restart", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
